// File: rtl/dmem_access_unit.sv
// Data-memory access unit for the M stage: byte/half/word loads and stores on an
// internal word array, with alignment/range checking and a req/ack stall handshake.
module dmem_access_unit #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned RD_LAT      = 1,
   parameter int unsigned ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              sign_ext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ack,
   output logic              addr_err,
   output logic              stall
);

   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
   localparam int unsigned CNT_W = 2;

   typedef enum logic [1:0] {IDLE, RWAIT, WDONE, ERR} state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_nxt;
   logic [IDX_W+1:0]   addr_q;
   logic [1:0]         size_q;
   logic               sign_q;

   logic               ack_nxt;
   logic               err_nxt;
   logic [31:0]        rdata_nxt;

   logic               illegal;
   logic               wr_en;
   logic [3:0]         be;
   logic [31:0]        wword;

   logic [IDX_W+1:0]   a_cur;
   logic [1:0]         sz_cur;
   logic               sx_cur;
   logic [31:0]        rd_word;
   logic [7:0]         byte_sel;
   logic [15:0]        half_sel;
   logic [31:0]        load_val;

   logic [31:0]        mem [DEPTH_WORDS];

   // Alignment and range rules for the request presented in IDLE
   always_comb begin
      illegal = 1'b0;
      case (size)
         2'b00:   illegal = 1'b0;
         2'b01:   illegal = addr[0];
         2'b10:   illegal = |addr[1:0];
         default: illegal = 1'b1;
      endcase
      if (addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH_WORDS)) begin
         illegal = 1'b1;
      end
   end

   // Little-endian lane enables with the store data replicated onto every lane
   always_comb begin
      be    = 4'b0000;
      wword = wdata;
      case (size)
         2'b00: begin
            be    = 4'b0001 << addr[1:0];
            wword = {4{wdata[7:0]}};
         end
         2'b01: begin
            be    = addr[1] ? 4'b1100 : 4'b0011;
            wword = {2{wdata[15:0]}};
         end
         default: begin
            be    = 4'b1111;
            wword = wdata;
         end
      endcase
   end

   assign wr_en = ~rst & (state == IDLE) & req & we & ~illegal;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
               mem[addr[IDX_W+1:2]][8*b +: 8] <= wword[8*b +: 8];
            end
         end
      end
   end

   // With RD_LAT=1 the result is formed in the accept cycle, so IDLE uses the live inputs
   always_comb begin
      a_cur  = addr_q;
      sz_cur = size_q;
      sx_cur = sign_q;
      if (state == IDLE) begin
         a_cur  = addr[IDX_W+1:0];
         sz_cur = size;
         sx_cur = sign_ext;
      end
   end

   assign rd_word = mem[a_cur[IDX_W+1:2]];

   always_comb begin
      byte_sel = rd_word[7:0];
      case (a_cur[1:0])
         2'd0:    byte_sel = rd_word[7:0];
         2'd1:    byte_sel = rd_word[15:8];
         2'd2:    byte_sel = rd_word[23:16];
         default: byte_sel = rd_word[31:24];
      endcase
      half_sel = a_cur[1] ? rd_word[31:16] : rd_word[15:0];
      case (sz_cur)
         2'b00:   load_val = {{24{sx_cur & byte_sel[7]}}, byte_sel};
         2'b01:   load_val = {{16{sx_cur & half_sel[15]}}, half_sel};
         default: load_val = rd_word;
      endcase
   end

   // State register, access latches and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         addr_q   <= '0;
         size_q   <= 2'b00;
         sign_q   <= 1'b0;
         ack      <= 1'b0;
         addr_err <= 1'b0;
         rdata    <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ack      <= ack_nxt;
         addr_err <= err_nxt;
         rdata    <= rdata_nxt;
         if ((state == IDLE) && req) begin
            addr_q <= addr[IDX_W+1:0];
            size_q <= size;
            sign_q <= sign_ext;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (req) begin
               if (illegal) begin
                  state_nxt = ERR;
               end else if (we) begin
                  state_nxt = WDONE;
               end else begin
                  state_nxt = RWAIT;
                  cnt_nxt   = CNT_W'(RD_LAT - 1);
               end
            end
         end
         RWAIT: begin
            if (cnt == '0) begin
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         WDONE:   state_nxt = IDLE;
         ERR:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs for the coming cycle: the completion cycle is the one spent in WDONE, ERR or RWAIT with cnt 0
   always_comb begin
      ack_nxt   = 1'b0;
      err_nxt   = 1'b0;
      rdata_nxt = rdata;
      case (state_nxt)
         WDONE: ack_nxt = 1'b1;
         ERR: begin
            ack_nxt = 1'b1;
            err_nxt = 1'b1;
         end
         RWAIT: begin
            if (cnt_nxt == '0) begin
               ack_nxt   = 1'b1;
               rdata_nxt = load_val;
            end
         end
         default: ack_nxt = 1'b0;
      endcase
   end

   assign stall = req & ~ack;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: two instances (RD_LAT 1 and 3) share one stimulus stream
// and are compared every cycle against an access-level reference model.
module tb_dmem_access_unit;

   localparam int unsigned DEPTH = 1024;

   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        sign_ext;
   logic [31:0] addr;
   logic [31:0] wdata;

   logic [31:0] rdata_v [2];
   logic [1:0]  ack_v;
   logic [1:0]  err_v;
   logic [1:0]  stall_v;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   dmem_access_unit #(.DEPTH_WORDS(DEPTH), .RD_LAT(1), .ADDR_W(32)) u_dut1 (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .rdata(rdata_v[0]), .ack(ack_v[0]),
      .addr_err(err_v[0]), .stall(stall_v[0]));

   dmem_access_unit #(.DEPTH_WORDS(DEPTH), .RD_LAT(3), .ADDR_W(32)) u_dut3 (
      .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
      .addr(addr), .wdata(wdata), .rdata(rdata_v[1]), .ack(ack_v[1]),
      .addr_err(err_v[1]), .stall(stall_v[1]));

   task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s lat%0d got %h expected %h at %0t", nm, inst, act, exp, $time);
      end
   endtask

   function automatic bit is_illegal(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'b11) return 1'b1;
      if (sz == 2'b01 && a[0]) return 1'b1;
      if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
      return (a >> 2) >= 32'(DEPTH);
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] sz,
                                         input logic [31:0] a, input logic [31:0] wd);
      logic [31:0] mask;
      logic [31:0] data;
      case (sz)
         2'b00: begin
            mask = 32'h0000_00FF << (8 * int'(a[1:0]));
            data = (wd & 32'h0000_00FF) << (8 * int'(a[1:0]));
         end
         2'b01: begin
            mask = 32'h0000_FFFF << (16 * int'(a[1]));
            data = (wd & 32'h0000_FFFF) << (16 * int'(a[1]));
         end
         default: begin
            mask = 32'hFFFF_FFFF;
            data = wd;
         end
      endcase
      return (old & ~mask) | (data & mask);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] sz,
                                           input logic sx, input logic [31:0] a);
      logic [31:0] v;
      case (sz)
         2'b00: begin
            v = (word >> (8 * int'(a[1:0]))) & 32'h0000_00FF;
            if (sx && v[7]) v |= 32'hFFFF_FF00;
         end
         2'b01: begin
            v = (word >> (16 * int'(a[1]))) & 32'h0000_FFFF;
            if (sx && v[15]) v |= 32'hFFFF_0000;
         end
         default: v = word;
      endcase
      return v;
   endfunction

   // Reference model: one pending access per instance, completing a fixed number of edges after acceptance
   logic [31:0] mm [2][DEPTH];
   int          left [2];
   bit          ackc [2];
   bit          errc [2];
   bit          perr [2];
   bit          pload [2];
   logic [31:0] pdata [2];
   logic [31:0] mrd [2];
   bit          mk;
   bit          was_ack;

   initial begin
      for (int i = 0; i < 2; i++) begin
         left[i] = 0; ackc[i] = 1'b0; errc[i] = 1'b0; perr[i] = 1'b0;
         pload[i] = 1'b0; pdata[i] = '0; mrd[i] = '0;
      end
   end

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         mk = 1'(i);
         if (rst) begin
            left[mk] = 0; ackc[mk] = 1'b0; errc[mk] = 1'b0; mrd[mk] = '0;
         end else begin
            was_ack = ackc[mk];
            ackc[mk] = 1'b0;
            errc[mk] = 1'b0;
            if (left[mk] == 0 && !was_ack && req) begin
               perr[mk]  = is_illegal(size, addr);
               pload[mk] = !we && !perr[mk];
               left[mk]  = pload[mk] ? (mk ? 3 : 1) : 1;
               if (!perr[mk] && we)
                  mm[mk][addr[11:2]] = merge(mm[mk][addr[11:2]], size, addr, wdata);
               if (pload[mk])
                  pdata[mk] = extract(mm[mk][addr[11:2]], size, sign_ext, addr);
            end
            if (left[mk] > 0) begin
               left[mk]--;
               if (left[mk] == 0) begin
                  ackc[mk] = 1'b1;
                  errc[mk] = perr[mk];
                  if (pload[mk]) mrd[mk] = pdata[mk];
               end
            end
         end
      end
   end

   bit ck;
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 2; i++) begin
            ck = 1'(i);
            chk("ack", ck ? 3 : 1, 32'(ack_v[ck]), 32'(ackc[ck]));
            chk("addr_err", ck ? 3 : 1, 32'(err_v[ck]), 32'(errc[ck]));
            chk("rdata", ck ? 3 : 1, rdata_v[ck], mrd[ck]);
            chk("stall", ck ? 3 : 1, 32'(stall_v[ck]), 32'(req & ~ackc[ck]));
         end
      end
   end

   function automatic logic [31:0] rand_addr();
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r <= 6) return 32'($urandom_range(0, 63));
      if (r == 7) return 32'(4 * (DEPTH - 4)) + 32'($urandom_range(0, 15));
      if (r == 8) return 32'(4 * DEPTH) + 32'($urandom_range(0, 15));
      return {1'b1, 31'($urandom)};
   endfunction

   // One handshake keyed on the RD_LAT=3 instance; returns its rdata, addr_err and cycles to ack
   task automatic access(input logic w, input logic [1:0] sz, input logic sx, input logic [31:0] a,
                         input logic [31:0] wd, input bit drop, input bit scr,
                         output logic [31:0] rd, output logic er, output int lat);
      @(posedge clk); #1;
      req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
         if (drop) req = 1'b0;
         if (scr) begin
            we = 1'($urandom_range(0, 1)); size = 2'($urandom_range(0, 3));
            sign_ext = 1'($urandom_range(0, 1)); addr = rand_addr(); wdata = $urandom;
         end
      end while (!ack_v[1] && lat < 20);
      if (!ack_v[1]) begin
         checks++; errors++;
         $display("FAIL ack_timeout got no ack expected ack within 20 cycles at %0t", $time);
      end
      rd = rdata_v[1];
      er = err_v[1];
      req = 1'b0;
   endtask

   task automatic rst_mid(input logic [31:0] a);
      @(posedge clk); #1;
      req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = a;
      @(posedge clk); #1;
      rst = 1'b1; req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_rdata", 3, rdata_v[1], 32'h0);
      chk("rst_ack", 3, 32'(ack_v[1]), 32'h0);
   endtask

   logic [31:0] rd;
   logic        er;
   int          lat;
   logic        rw;
   logic [1:0]  rsz;
   logic [31:0] ra;

   initial begin
      rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0; addr = '0; wdata = '0;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("reset_ack", 3, 32'(ack_v[1]), 32'h0);
      chk("reset_err", 3, 32'(err_v[1]), 32'h0);
      chk("reset_rdata", 3, rdata_v[1], 32'h0);
      chk("reset_stall", 3, 32'(stall_v[1]), 32'h0);

      // Fill every word the random traffic can reach
      for (int w = 0; w < 16; w++) access(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom, 1'b0, 1'b0, rd, er, lat);
      for (int w = DEPTH - 4; w < DEPTH; w++) access(1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom, 1'b0, 1'b0, rd, er, lat);

      access(1'b1, 2'b10, 1'b0, 32'h8, 32'hA1B2_C3D4, 1'b0, 1'b0, rd, er, lat);
      chk("sw_lat", 3, 32'(lat), 32'd1);
      access(1'b1, 2'b00, 1'b0, 32'h9, 32'h0000_0055, 1'b0, 1'b0, rd, er, lat);
      access(1'b0, 2'b10, 1'b0, 32'h8, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lw_8", 3, rd, 32'hA1B2_55D4);
      chk("model_lw_8", 3, mrd[1], 32'hA1B2_55D4);
      chk("lw_lat", 3, 32'(lat), 32'd3);
      access(1'b0, 2'b00, 1'b1, 32'h9, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lb_9", 3, rd, 32'h0000_0055);
      access(1'b0, 2'b00, 1'b1, 32'hB, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lb_b", 3, rd, 32'hFFFF_FFA1);
      chk("model_lb_b", 3, mrd[1], 32'hFFFF_FFA1);
      access(1'b0, 2'b01, 1'b0, 32'hA, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lhu_a", 3, rd, 32'h0000_A1B2);
      access(1'b0, 2'b01, 1'b1, 32'h8, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lh_8", 3, rd, 32'h0000_55D4);

      access(1'b0, 2'b10, 1'b0, 32'h6, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lw_6_err", 3, 32'(er), 32'h1);
      chk("lw_6_lat", 3, 32'(lat), 32'd1);
      chk("lw_6_rdata", 3, rd, 32'h0000_55D4);

      access(1'b1, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 1'b0, 1'b0, rd, er, lat);
      access(1'b1, 2'b01, 1'b0, 32'h3, 32'h0000_BEEF, 1'b0, 1'b0, rd, er, lat);
      chk("sh_3_err", 3, 32'(er), 32'h1);
      access(1'b0, 2'b10, 1'b0, 32'h0, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lw_0_kept", 3, rd, 32'h1122_3344);

      access(1'b0, 2'b10, 1'b0, 32'h1000, '0, 1'b0, 1'b0, rd, er, lat);
      chk("lw_1000_err", 3, 32'(er), 32'h1);

      access(1'b0, 2'b10, 1'b0, 32'h8, '0, 1'b1, 1'b0, rd, er, lat);
      chk("drop_rdata", 3, rd, 32'hA1B2_55D4);
      chk("drop_lat", 3, 32'(lat), 32'd3);

      rst_mid(32'h8);
      access(1'b0, 2'b00, 1'b1, 32'hB, '0, 1'b0, 1'b0, rd, er, lat);
      chk("after_rst_lb", 3, rd, 32'hFFFF_FFA1);
      chk("after_rst_lat", 3, 32'(lat), 32'd3);

      for (int n = 0; n < 300; n++) begin
         rw  = 1'($urandom_range(0, 1));
         rsz = 2'($urandom_range(0, 3));
         ra  = rand_addr();
         access(rw, rsz, 1'($urandom_range(0, 1)), ra, $urandom,
                $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), rd, er, lat);
         chk("rand_lat", 3, 32'(lat), (rw || is_illegal(rsz, ra)) ? 32'd1 : 32'd3);
         if ($urandom_range(0, 29) == 0) rst_mid(32'(4 * $urandom_range(0, 15)));
      end

      @(posedge clk); #1;
      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Parametrised data-memory subsystem for the M stage of the MIPS pipeline; the next generation of the word-only data RAM hookup.
- Adds byte/halfword/word loads and stores, little-endian byte lanes, sign/zero extension, alignment and range checking, and configurable read latency.
- The pipeline stalls on a handshake instead of relying on an inverted-clock RAM.
- Contains its own word array; one access in flight at a time.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; power of 2; legal addresses are 0 .. 4*DEPTH_WORDS-1.
- RD_LAT, 1, cycles from load acceptance to ack; legal range 1..4.
- ADDR_W, 32, width of the byte address port.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  1  access request from the M stage; held until ack.
- we  in  1  1 = store, 0 = load; sampled with req.
- size  in  2  00 byte, 01 half, 10 word; 11 is illegal and handled as a misaligned access.
- sign_ext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-justified: byte in [7:0], half in [15:0].
- rdata  out  32  extended load result; valid in the ack cycle and held until the next load ack.
- ack  out  1  one-cycle completion pulse.
- addr_err  out  1  high together with ack when the access was rejected.
- stall  out  1  combinational req & ~ack; freezes F/D/E/M.

Behaviour:
- Reset: state IDLE; ack=0, addr_err=0, rdata=0. The array is not cleared and is zero-initialised at time 0 in simulation only.
- States:
  - IDLE: req=1 accepts the access. If the access is illegal, go to ERR. If it is a store, go to WDONE. If it is a load, go to RWAIT with the latency counter set to RD_LAT-1.
  - RWAIT: decrement the counter each cycle. When the counter reaches 0, load the result into rdata, pulse ack, and return to IDLE.
  - WDONE: pulse ack, return to IDLE.
  - ERR: pulse ack and addr_err, return to IDLE.
- Accept edge: addr, we, size and sign_ext are latched into registers; later input changes are ignored.
- Latency: a store, or any illegal access, acks 1 cycle after acceptance. A load acks RD_LAT cycles after acceptance.
- Back-to-back: a new request is accepted only in IDLE. After ack, the earliest next acceptance is the following edge, so there is one idle cycle between accesses.
- Illegal access means any of:
  - size=01 with addr[0]=1;
  - size=10 with addr[1:0]!=00;
  - size=11;
  - addr[ADDR_W-1:2] >= DEPTH_WORDS.
  An illegal access performs no write, leaves rdata unchanged, and raises addr_err.
- Store lanes (little-endian), written on the accept edge:
  - Byte: lane addr[1:0] gets wdata[7:0].
  - Half: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - Word: all four lanes get wdata.
  - Untouched lanes keep their old value.
- Load: read the word, select the lane(s) as for stores, right-justify, then extend. Sign extension uses bit 7 (byte) or bit 15 (half). The sign_ext value is ignored for word loads.
- Read-after-write: a load accepted after a store's ack returns the new data.
- Abort cases:
  - req dropped while in RWAIT: the access still completes and ack pulses.
  - rst asserted in any state: return to IDLE next edge with no ack and rdata=0. A store already accepted stays written.
- ack and addr_err are never high outside the completion cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0 -> ack=0, addr_err=0, rdata=0, stall=0.
- Store and load sizes, RD_LAT=1:
  - SW 0x8 = 0xA1B2C3D4, then SB 0x9 = 0x55.
  - LW 0x8 -> 0xA1B255D4.
  - LB 0x9 sign -> 0x00000055.
  - LB 0xB sign -> 0xFFFFFFA1.
  - LHU 0xA -> 0x0000A1B2.
  - LH 0x8 -> 0x000055D4.
- Latency, RD_LAT=3: LW accepted at cycle N -> ack at N+3; stall=1 for cycles N..N+2, 0 at N+3.
- Illegal accesses:
  - LW 0x6 -> ack and addr_err one cycle after acceptance, rdata unchanged.
  - SH 0x3 -> no memory change.
  - LW 0x1000 with DEPTH_WORDS=1024 -> addr_err.
- req dropped in RWAIT: ack still pulses with correct data.
- rst during RWAIT: no ack, rdata=0, and the next request is accepted normally.
